alu_op_sequencer: RTL

//  Accepts 16-bit ALU instructions over a valid/ready handshake and buffers them in a small FIFO.

---
 rtl/alu_op_sequencer_pkg.sv | 34 +++
 rtl/alu_op_sequencer_fifo.sv | 54 +++++
 rtl/alu_op_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU op sequencer: FSM states, the 16-bit instruction layout
// and the ALU opcode encodings.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        EX   = 2'd2,
        WB   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       dst_bank;
        logic [2:0] dst_idx;
        logic       wb_en;
        logic [1:0] rsvd;
    } alu_instr_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_NAND = 3'b111;

    // Indices 0/1 of alu_regs have side effects on read, so idle selects park here.
    localparam logic [2:0] RD_PARK = 3'd2;

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Small synchronous instruction FIFO with occupancy count; push and pop in the same
// cycle are both honoured.
module alu_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU instructions and walks each through operand read, execute and
// optional write-back, acting as sole master of the register file and ALU.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [2:0]        rf_rd_slct_a,
    output logic [2:0]        rf_rd_slct_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    output logic              rf_wrtnbl,
    output logic [6:0]        rf_wrt_slct,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_zero,
    output logic              busy,
    output logic [CNT_W-1:0]  retired_cnt
);
    seq_state_e        state;
    alu_instr_t        cur;
    alu_instr_t        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] res_q;
    logic              carry_q;
    logic              zero_q;
    logic              unused_rsvd;

    // The head is popped on the same edge that moves the FSM into RD.
    assign fifo_pop = ((state == IDLE) || (state == WB)) && !fifo_empty;

    alu_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(alu_instr_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (instr_valid),
        .pop   (fifo_pop),
        .din   (instr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= fifo_head;
                        state <= RD;
                    end
                end
                RD: begin
                    alu_a      <= rf_data_a;
                    alu_b      <= rf_data_b;
                    alu_opcode <= cur.op;
                    state      <= EX;
                end
                EX: begin
                    res_q   <= alu_c;
                    carry_q <= alu_carry;
                    zero_q  <= alu_zero;
                    state   <= WB;
                end
                WB: begin
                    retired_cnt <= retired_cnt + 1'b1;
                    if (!fifo_empty) begin
                        cur   <= fifo_head;
                        state <= RD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign instr_ready  = !fifo_full;
    assign busy         = (state != IDLE) || !fifo_empty;
    assign rf_rd_slct_a = (state == RD) ? cur.ra : RD_PARK;
    assign rf_rd_slct_b = (state == RD) ? cur.rb : RD_PARK;
    // Write strobe is purely state-derived so an async reset kills it at once.
    assign res_valid    = (state == WB);
    assign rf_wrtnbl    = (state == WB) && cur.wb_en;
    assign rf_wrt_slct  = {3'b000, cur.dst_bank, cur.dst_idx};
    assign rf_data_in   = res_q;
    assign res_data     = res_q;
    assign res_carry    = carry_q;
    assign res_zero     = zero_q;
    assign unused_rsvd  = ^cur.rsvd;

endmodule
